// File: rtl/sr_pkg.sv
// Shared definitions for the status register block: SR bit positions, write masks
// and the interrupt-save FSM state encoding.
package sr_pkg;

    localparam int SR_C      = 0;
    localparam int SR_Z      = 1;
    localparam int SR_N      = 2;
    localparam int SR_GIE    = 3;
    localparam int SR_CPUOFF = 4;
    localparam int SR_OSCOFF = 5;
    localparam int SR_SCG0   = 6;
    localparam int SR_SCG1   = 7;
    localparam int SR_V      = 8;

    // Bits 15:9 are unimplemented; every SR write passes through this mask.
    localparam logic [15:0] SR_WMASK    = 16'h01FF;
    // SCG0 survives interrupt entry; every other SR bit is cleared.
    localparam logic [15:0] SR_IRQ_KEEP = 16'h0040;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_DONE = 2'd2
    } sr_state_t;

endpackage

// File: rtl/sr_reg.sv
// Status register with interrupt-entry save (snapshot, push, clear) and RETI restore.
// All outputs come straight from flops; nothing combinational from inputs.
module sr_reg
    import sr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] reg_SR_in,
    input  logic        sr_we,
    input  logic        irq_accept,
    output logic        save_valid,
    input  logic        save_ready,
    output logic [15:0] save_data,
    input  logic        reti_valid,
    input  logic [15:0] reti_data,
    output logic        reti_ready,
    output logic [15:0] reg_SR_out,
    output logic        gie,
    output logic        cpuoff,
    output logic        oscoff,
    output logic        scg0,
    output logic        scg1,
    output logic        irq_done,
    output sr_state_t   state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // save_valid stays high and save_data stays stable until that edge; reti_ready is
    // high only in IDLE, and a reti_valid seen while it is low is not consumed.

    sr_state_t   state;
    logic [15:0] sr;
    logic [15:0] snap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sr         <= 16'h0000;
            snap       <= 16'h0000;
            save_valid <= 1'b0;
            irq_done   <= 1'b0;
            reti_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    irq_done   <= 1'b0;
                    reti_ready <= 1'b1;
                    // Lower-priority requests in the same cycle are dropped, not held.
                    if (irq_accept) begin
                        snap       <= sr;
                        save_valid <= 1'b1;
                        reti_ready <= 1'b0;
                        state      <= ST_PUSH;
                    end else if (reti_valid && reti_ready) begin
                        sr <= reti_data & SR_WMASK;
                    end else if (sr_we) begin
                        sr <= reg_SR_in & SR_WMASK;
                    end
                end
                ST_PUSH: begin
                    if (save_ready) begin
                        sr         <= sr & SR_IRQ_KEEP;
                        save_valid <= 1'b0;
                        irq_done   <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    irq_done   <= 1'b0;
                    reti_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    save_valid <= 1'b0;
                    irq_done   <= 1'b0;
                    reti_ready <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign save_data  = snap;
    assign reg_SR_out = sr;
    assign gie        = sr[SR_GIE];
    assign cpuoff     = sr[SR_CPUOFF];
    assign oscoff     = sr[SR_OSCOFF];
    assign scg0       = sr[SR_SCG0];
    assign scg1       = sr[SR_SCG1];
    assign state_dbg  = state;

endmodule

// File: tb/tb_sr_reg.sv
// Self-checking bench for sr_reg: directed scenarios plus a randomised interrupt run,
// with expected save words kept in a queue and compared at each save handshake.
module tb_sr_reg;
    import sr_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] reg_SR_in;
    logic        sr_we;
    logic        irq_accept;
    logic        save_valid;
    logic        save_ready;
    logic [15:0] save_data;
    logic        reti_valid;
    logic [15:0] reti_data;
    logic        reti_ready;
    logic [15:0] reg_SR_out;
    logic        gie, cpuoff, oscoff, scg0, scg1;
    logic        irq_done;
    sr_state_t   state_dbg;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_sr;
    logic [15:0] exp_word;

    sr_reg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_SR_in  (reg_SR_in),
        .sr_we      (sr_we),
        .irq_accept (irq_accept),
        .save_valid (save_valid),
        .save_ready (save_ready),
        .save_data  (save_data),
        .reti_valid (reti_valid),
        .reti_data  (reti_data),
        .reti_ready (reti_ready),
        .reg_SR_out (reg_SR_out),
        .gie        (gie),
        .cpuoff     (cpuoff),
        .oscoff     (oscoff),
        .scg0       (scg0),
        .scg1       (scg1),
        .irq_done   (irq_done),
        .state_dbg  (state_dbg)
    );

    // Clock and cycle step: inputs change and outputs are sampled 1ns after the edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sr(input logic [15:0] val);
        sr_we     = 1'b1;
        reg_SR_in = val;
        step();
        sr_we     = 1'b0;
        model_sr  = val & 16'h01FF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (reg_SR_out !== 16'h0000) begin errors++; $display("FAIL reset_sr: got %h want 0000", reg_SR_out); end
        checks++;
        if ({save_valid, irq_done, reti_ready} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: valid/done/ready got %b want 000", {save_valid, irq_done, reti_ready});
        end
        checks++;
        if (save_data !== 16'h0000) begin errors++; $display("FAIL reset_save_data: got %h want 0000", save_data); end
        checks++;
        if ({gie, cpuoff, oscoff, scg0, scg1} !== 5'b00000) begin
            errors++; $display("FAIL reset_decoded: got %b want 00000", {gie, cpuoff, oscoff, scg0, scg1});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (reti_ready !== 1'b1 || state_dbg !== ST_IDLE) begin
            errors++; $display("FAIL reset_release: reti_ready=%b state=%0d want 1 / IDLE", reti_ready, state_dbg);
        end
        model_sr = 16'h0000;
    endtask

    task automatic test_sr_write();
        write_sr(16'hFFFF);
        checks++;
        if (reg_SR_out !== 16'h01FF) begin errors++; $display("FAIL write_mask: got %h want 01ff", reg_SR_out); end
        checks++;
        if ({gie, cpuoff, oscoff, scg0, scg1} !== 5'b11111) begin
            errors++; $display("FAIL write_decoded: got %b want 11111", {gie, cpuoff, oscoff, scg0, scg1});
        end
        for (int i = 0; i < 4; i++) begin
            write_sr(16'($urandom_range(0, 65535)));
            checks++;
            if (reg_SR_out !== model_sr) begin errors++; $display("FAIL write_rand%0d: got %h want %h", i, reg_SR_out, model_sr); end
        end
    endtask

    task automatic test_irq_stall();
        write_sr(16'h0058);
        irq_accept = 1'b1;
        exp_q.push_back(model_sr);
        step();
        irq_accept = 1'b0;
        checks++;
        if (save_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", save_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (save_valid !== 1'b1 || reg_SR_out !== 16'h0058 || irq_done !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: valid=%b sr=%h done=%b want 1/0058/0", i, save_valid, reg_SR_out, irq_done);
            end
        end
        exp_word = exp_q.pop_front();
        checks++;
        if (save_data !== exp_word) begin errors++; $display("FAIL stall_data: got %h want %h", save_data, exp_word); end
        save_ready = 1'b1;
        step();
        save_ready = 1'b0;
        checks++;
        if (reg_SR_out !== 16'h0040 || irq_done !== 1'b1 || save_valid !== 1'b0) begin
            errors++; $display("FAIL stall_done: sr=%h done=%b valid=%b want 0040/1/0", reg_SR_out, irq_done, save_valid);
        end
        step();
        checks++;
        if (irq_done !== 1'b0 || reti_ready !== 1'b1) begin
            errors++; $display("FAIL stall_pulse: done=%b ready=%b want 0/1", irq_done, reti_ready);
        end
        model_sr = 16'h0040;
    endtask

    task automatic test_priority();
        write_sr(16'h0070);
        irq_accept = 1'b1;
        sr_we      = 1'b1;
        reg_SR_in  = 16'h0001;
        reti_valid = 1'b1;
        reti_data  = 16'h00FF;
        exp_q.push_back(model_sr);
        step();
        irq_accept = 1'b0;
        sr_we      = 1'b0;
        exp_word   = exp_q.pop_front();
        checks++;
        if (save_data !== exp_word || reg_SR_out !== 16'h0070) begin
            errors++; $display("FAIL prio_snapshot: data=%h sr=%h want %h/0070", save_data, reg_SR_out, exp_word);
        end
        checks++;
        if (reti_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_push: got %b want 0", reti_ready); end
        save_ready = 1'b1;
        step();
        save_ready = 1'b0;
        checks++;
        if (reti_ready !== 1'b0 || irq_done !== 1'b1 || reg_SR_out !== 16'h0040) begin
            errors++; $display("FAIL prio_done: ready=%b done=%b sr=%h want 0/1/0040", reti_ready, irq_done, reg_SR_out);
        end
        reti_valid = 1'b0;
        step();
        checks++;
        if (reg_SR_out !== 16'h0040 || reti_ready !== 1'b1) begin
            errors++; $display("FAIL prio_idle: sr=%h ready=%b want 0040/1", reg_SR_out, reti_ready);
        end
        model_sr = 16'h0040;
    endtask

    task automatic test_reti();
        reti_valid = 1'b1;
        reti_data  = 16'hFE18;
        step();
        reti_valid = 1'b0;
        model_sr   = 16'h0018;
        checks++;
        if (reg_SR_out !== model_sr || gie !== 1'b1 || cpuoff !== 1'b1 || oscoff !== 1'b0) begin
            errors++; $display("FAIL reti_restore: sr=%h gie=%b cpuoff=%b oscoff=%b want 0018/1/1/0", reg_SR_out, gie, cpuoff, oscoff);
        end
    endtask

    task automatic test_reset_mid_push();
        write_sr(16'h0048);
        irq_accept = 1'b1;
        exp_q.push_back(model_sr);
        step();
        irq_accept = 1'b0;
        checks++;
        if (save_valid !== 1'b1) begin errors++; $display("FAIL rstpush_valid: got %b want 1", save_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (save_valid !== 1'b0 || reg_SR_out !== 16'h0000 || save_data !== 16'h0000 || reti_ready !== 1'b0) begin
            errors++; $display("FAIL rstpush_async: valid=%b sr=%h data=%h ready=%b want 0/0000/0000/0", save_valid, reg_SR_out, save_data, reti_ready);
        end
        void'(exp_q.pop_front());
        save_ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (irq_done !== 1'b0 || save_valid !== 1'b0 || reg_SR_out !== 16'h0000) begin
                errors++; $display("FAIL rstpush_after%0d: done=%b valid=%b sr=%h want 0/0/0000", i, irq_done, save_valid, reg_SR_out);
            end
        end
        save_ready = 1'b0;
        model_sr   = 16'h0000;
    endtask

    task automatic test_we_during_push();
        write_sr(16'h00C8);
        irq_accept = 1'b1;
        exp_q.push_back(model_sr);
        step();
        sr_we      = 1'b1;
        reg_SR_in  = 16'h0107;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (reg_SR_out !== 16'h00C8 || state_dbg !== ST_PUSH) begin
                errors++; $display("FAIL wepush_hold%0d: sr=%h state=%0d want 00c8/PUSH", i, reg_SR_out, state_dbg);
            end
        end
        irq_accept = 1'b0;
        exp_word   = exp_q.pop_front();
        checks++;
        if (save_data !== exp_word) begin errors++; $display("FAIL wepush_data: got %h want %h", save_data, exp_word); end
        save_ready = 1'b1;
        step();
        save_ready = 1'b0;
        model_sr   = exp_word & 16'h0040;
        checks++;
        if (reg_SR_out !== model_sr || irq_done !== 1'b1) begin
            errors++; $display("FAIL wepush_clear: sr=%h done=%b want %h/1", reg_SR_out, irq_done, model_sr);
        end
        step();
        sr_we = 1'b0;
        checks++;
        if (reg_SR_out !== model_sr || state_dbg !== ST_IDLE) begin
            errors++; $display("FAIL wepush_done: sr=%h state=%0d want %h/IDLE", reg_SR_out, state_dbg, model_sr);
        end
    endtask

    task automatic test_back_to_back();
        int stall;
        for (int n = 0; n < 6; n++) begin
            write_sr(16'($urandom_range(0, 65535)));
            irq_accept = 1'b1;
            exp_q.push_back(model_sr);
            step();
            irq_accept = 1'b0;
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) step();
            exp_word = exp_q.pop_front();
            checks++;
            if (save_valid !== 1'b1 || save_data !== exp_word) begin
                errors++; $display("FAIL b2b_save%0d: valid=%b data=%h want 1/%h", n, save_valid, save_data, exp_word);
            end
            save_ready = 1'b1;
            step();
            save_ready = 1'b0;
            model_sr   = exp_word & 16'h0040;
            checks++;
            if (irq_done !== 1'b1 || reg_SR_out !== model_sr) begin
                errors++; $display("FAIL b2b_done%0d: done=%b sr=%h want 1/%h", n, irq_done, reg_SR_out, model_sr);
            end
            step();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        reg_SR_in  = 16'h0000;
        sr_we      = 1'b0;
        irq_accept = 1'b0;
        save_ready = 1'b0;
        reti_valid = 1'b0;
        reti_data  = 16'h0000;
        model_sr   = 16'h0000;
        test_reset();
        test_sr_write();
        test_irq_stall();
        test_priority();
        test_reti();
        test_reset_mid_push();
        test_we_during_push();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_reg.md
SR_REG -- requirements
Module: sr_reg

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port reg_SR_in  input  16  next SR value from the SR input mux (flags or SR hold).
REQ-004 SHALL have port sr_we  input  1  load reg_SR_in into SR this cycle.
REQ-005 SHALL have port irq_accept  input  1  one-cycle pulse: interrupt accepted, start SR save.
REQ-006 SHALL have port save_valid  output  1  SR snapshot offered to stack writer.
REQ-007 SHALL have port save_ready  input  1  stack writer accepts save_data.
REQ-008 SHALL have port save_data  output  16  SR snapshot being pushed.
REQ-009 SHALL have port reti_valid  input  1  restored SR word popped by RETI is present.
REQ-010 SHALL have port reti_data  input  16  popped SR word.
REQ-011 SHALL have port reti_ready  output  1  block can accept reti_data this cycle.
REQ-012 SHALL have port reg_SR_out  output  16  current SR, fed back to the SR input mux.
REQ-013 SHALL have port gie, cpuoff, oscoff, scg0, scg1  output  1 each  decoded SR control bits.
REQ-014 SHALL have port irq_done  output  1  one-cycle pulse: SR save and clear complete.

Function
REQ-015 SR bit map SHALL be C=0, Z=1, N=2, GIE=3, CPUOFF=4, OSCOFF=5, SCG0=6, SCG1=7, V=8; bits 15:9 always read 0 and SHALL be masked on every write.
REQ-016 FSM states SHALL be IDLE, PUSH, DONE.
REQ-017 IDLE: irq_accept=1 -> capture SR into snapshot register, go PUSH next cycle.
REQ-018 PUSH: save_valid=1, save_data=snapshot (stable until handshake); save_valid&save_ready -> SR <= SR & 0x0040 (SCG0 kept, all else 0), go DONE.
REQ-019 PUSH with save_ready=0 SHALL hold indefinitely, SR unchanged.
REQ-020 DONE: irq_done=1 for exactly one cycle, then IDLE unconditionally.
REQ-021 reti_ready SHALL be 1 only in IDLE; reti_valid&reti_ready -> SR <= reti_data & 0x01FF next edge.
REQ-022 sr_we in IDLE without reti handshake or irq_accept -> SR <= reg_SR_in & 0x01FF next edge.
REQ-023 Priority in IDLE, same cycle: irq_accept > reti handshake > sr_we; lower-priority requests SHALL be dropped, not queued.
REQ-024 irq_accept captures SR value before any same-cycle sr_we/reti update (pre-edge SR).
REQ-025 sr_we and irq_accept outside IDLE SHALL be ignored; SR is modified only by REQ-018 in PUSH.
REQ-026 reg_SR_out and decoded bits SHALL be registered SR, zero combinational path from inputs.
REQ-027 Latency: irq_accept to save_valid = 1 cycle; save handshake to irq_done = 1 cycle.

Reset
REQ-028 rst_n low SHALL asynchronously force SR=0x0000, snapshot=0x0000, state=IDLE.
REQ-029 During reset: save_valid=0, save_data=0, irq_done=0, reti_ready=0, all decoded bits 0.
REQ-030 Reset asserted mid-PUSH SHALL abandon the push; no irq_done after release.
REQ-031 After release reti_ready=1 from first clock edge (IDLE).

Structure
REQ-032 Shared package sr_pkg SHALL hold SR bit indices, SR_WMASK=0x01FF, SR_IRQ_KEEP=0x0040, state enum.
REQ-033 Single flat module; no sub-module; target 120-250 lines RTL.

Verification
REQ-034 Reset then sr_we=1, reg_SR_in=0xFFFF -> reg_SR_out=0x01FF, gie=cpuoff=oscoff=scg0=scg1=1.
REQ-035 SR=0x0058, irq_accept -> next cycle save_valid=1, save_data=0x0058; save_ready held 0 for 3 cycles -> stall, SR stays 0x0058; save_ready=1 -> SR=0x0040, irq_done pulse 1 cycle.
REQ-036 Same cycle irq_accept, sr_we (0x0001), reti_valid -> save_data equals pre-edge SR, sr_we/reti dropped, reti_ready=0 during PUSH/DONE.
REQ-037 IDLE, reti_valid=1, reti_data=0xFE18 -> SR=0x0018, gie=1, cpuoff=1.
REQ-038 rst_n low during PUSH -> save_valid=0 immediately (async), no irq_done after release, SR=0x0000.
REQ-039 sr_we pulses during PUSH with reg_SR_in=0x0107 -> ignored, SR after handshake equals SR_IRQ_KEEP masking of original.
